word_splitter: RTL and testbench

Transmit-side counterpart of the 128-bit half-word assembler. It accepts full `TOTAL_WIDTH`-bit words over a valid/ready handshake and emits them toward the assembler. Normal words go out as two half-words, lower half first, each placed on `o_word[TOTAL_WIDTH-1:HALF]`. Words tagged with the push flag go out intact in a single beat.

---
 rtl/word_pkg.sv | 21 ++
 rtl/word_splitter.sv | 111 +++++++++++
 tb/tb_word_splitter.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/word_pkg.sv
// ============================================================================
// Module      : word_pkg
// Description : Shared types and defaults for the half-word splitter.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package word_pkg;

    localparam int TOTAL_WIDTH_DEFAULT = 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        FULL = 2'd3
    } split_state_t;

endpackage

`default_nettype wire

// File: rtl/word_splitter.sv
// ============================================================================
// Module      : word_splitter
// Description : Emits each accepted word as two upper-aligned half-word beats,
//               or whole in one beat when tagged with the push flag.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module word_splitter
    import word_pkg::*;
#(
    parameter int TOTAL_WIDTH = TOTAL_WIDTH_DEFAULT
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [TOTAL_WIDTH-1:0] i_word,
    input  logic                   i_push_flag,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [TOTAL_WIDTH-1:0] o_word,
    output logic                   o_push_flag,
    output logic                   o_half,
    output logic [15:0]            o_word_cnt
);

    localparam int HALF = TOTAL_WIDTH / 2;

    split_state_t           r_state;
    split_state_t           w_next_state;
    logic [TOTAL_WIDTH-1:0] r_word;
    logic                   r_flag;
    logic [15:0]            r_cnt;

    logic w_beat_done;
    logic w_last_beat_done;
    logic w_accept;

    always_comb begin
        o_valid          = (r_state != IDLE);
        w_beat_done      = o_valid && i_ready;
        w_last_beat_done = w_beat_done && ((r_state == HIGH) || (r_state == FULL));
        o_ready          = i_reset && ((r_state == IDLE) || w_last_beat_done);
        w_accept         = i_valid && o_ready;
    end

    // A finishing word can hand over directly to the next one, so HIGH/FULL
    // share the accept branch with IDLE.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) w_next_state = i_push_flag ? FULL : LOW;
            end
            LOW: begin
                if (w_beat_done) w_next_state = HIGH;
            end
            HIGH, FULL: begin
                if (w_beat_done) begin
                    if (w_accept) w_next_state = i_push_flag ? FULL : LOW;
                    else          w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= IDLE;
            r_word  <= '0;
            r_flag  <= 1'b0;
            r_cnt   <= 16'd0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_word <= i_word;
                r_flag <= i_push_flag;
            end
            if (w_last_beat_done) r_cnt <= r_cnt + 16'd1;
        end
    end

    always_comb begin
        o_word      = '0;
        o_half      = 1'b0;
        o_push_flag = 1'b0;
        case (r_state)
            LOW: begin
                o_word[TOTAL_WIDTH-1:HALF] = r_word[HALF-1:0];
            end
            HIGH: begin
                o_word[TOTAL_WIDTH-1:HALF] = r_word[TOTAL_WIDTH-1:HALF];
                o_half                     = 1'b1;
            end
            FULL: begin
                o_word      = r_word;
                o_push_flag = r_flag;
            end
            default: begin
                o_word = '0;
            end
        endcase
    end

    assign o_word_cnt = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_word_splitter.sv
// Directed bench for word_splitter: vector table plus backpressure,
// back-to-back, reset-in-HIGH and counter-wrap sequences.
`default_nettype none

module tb_word_splitter;

    logic         clk;
    logic         i_reset;
    logic         i_valid;
    logic         o_ready;
    logic [127:0] i_word;
    logic         i_push_flag;
    logic         o_valid;
    logic         i_ready;
    logic [127:0] o_word;
    logic         o_push_flag;
    logic         o_half;
    logic [15:0]  o_word_cnt;

    int n_total;
    int n_pass;
    int exp_cnt;

    word_splitter #(.TOTAL_WIDTH(128)) dut (
        .i_clk       (clk),
        .i_reset     (i_reset),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_word      (i_word),
        .i_push_flag (i_push_flag),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_word      (o_word),
        .o_push_flag (o_push_flag),
        .o_half      (o_half),
        .o_word_cnt  (o_word_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] word;
        logic         flag;
        logic [127:0] beat0;
        logic [127:0] beat1;
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic check_idle();
        chk("idle_valid", o_valid, 0);
        chk("idle_word",  o_word, 0);
        chk("idle_cnt",   o_word_cnt, exp_cnt);
    endtask

    task automatic apply_vec(input vec_t v);
        @(negedge clk);
        i_word = v.word; i_push_flag = v.flag; i_valid = 1'b1; i_ready = 1'b1;
        #1 chk("accept_ready", o_ready, 1);
        @(posedge clk); #1;
        i_valid = 1'b0; i_word = ~v.word; i_push_flag = ~v.flag;
        @(negedge clk);
        chk("b0_valid", o_valid, 1);
        chk("b0_word",  o_word, v.beat0);
        chk("b0_half",  o_half, 0);
        chk("b0_push",  o_push_flag, v.flag);
        chk("b0_ready", o_ready, v.flag);
        if (!v.flag) begin
            @(negedge clk);
            chk("b1_valid", o_valid, 1);
            chk("b1_word",  o_word, v.beat1);
            chk("b1_half",  o_half, 1);
            chk("b1_push",  o_push_flag, 0);
            chk("b1_ready", o_ready, 1);
        end
        exp_cnt++;
        @(negedge clk);
        check_idle();
    endtask

    logic [127:0] b2b_words [4];
    logic         b2b_flags [4];
    logic [127:0] b2b_beats [6];
    logic         b2b_ready [6];

    initial begin
        n_total = 0; n_pass = 0; exp_cnt = 0;
        i_reset = 1'b0; i_valid = 1'b0; i_word = '0; i_push_flag = 1'b0; i_ready = 1'b0;

        vecs[0] = '{128'hAAAAAAAAAAAAAAAA_5555555555555555, 1'b0,
                    128'h5555555555555555_0000000000000000,
                    128'hAAAAAAAAAAAAAAAA_0000000000000000};
        vecs[1] = '{128'h0123456789ABCDEF_0123456789ABCDEF, 1'b1,
                    128'h0123456789ABCDEF_0123456789ABCDEF, 128'h0};
        vecs[2] = '{128'hDEADBEEFCAFEF00D_0011223344556677, 1'b0,
                    128'h0011223344556677_0000000000000000,
                    128'hDEADBEEFCAFEF00D_0000000000000000};
        vecs[3] = '{128'hFFFFFFFFFFFFFFFF_FFFFFFFFFFFFFFFF, 1'b1,
                    128'hFFFFFFFFFFFFFFFF_FFFFFFFFFFFFFFFF, 128'h0};

        // Reset state
        @(negedge clk); @(negedge clk);
        chk("rst_valid", o_valid, 0);
        chk("rst_word",  o_word, 0);
        chk("rst_push",  o_push_flag, 0);
        chk("rst_half",  o_half, 0);
        chk("rst_cnt",   o_word_cnt, 0);
        chk("rst_ready", o_ready, 0);
        i_reset = 1'b1;

        for (int i = 0; i < 4; i++) apply_vec(vecs[i]);

        // Backpressure in LOW
        @(negedge clk);
        i_word = vecs[2].word; i_push_flag = 1'b0; i_valid = 1'b1; i_ready = 1'b0;
        @(posedge clk); #1;
        i_word = 128'h1; i_push_flag = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_valid", o_valid, 1);
            chk("bp_word",  o_word, vecs[2].beat0);
            chk("bp_half",  o_half, 0);
            chk("bp_ready", o_ready, 0);
        end
        i_valid = 1'b0; i_ready = 1'b1;
        @(negedge clk);
        chk("bp_hi_word", o_word, vecs[2].beat1);
        chk("bp_hi_half", o_half, 1);
        exp_cnt++;
        @(negedge clk);
        check_idle();

        // Back-to-back: split A, whole B, split C, whole D
        b2b_words[0] = 128'h1111111111111111_2222222222222222; b2b_flags[0] = 1'b0;
        b2b_words[1] = 128'h3333333333333333_4444444444444444; b2b_flags[1] = 1'b1;
        b2b_words[2] = 128'h5555555555555555_6666666666666666; b2b_flags[2] = 1'b0;
        b2b_words[3] = 128'h7777777777777777_8888888888888888; b2b_flags[3] = 1'b1;
        b2b_beats[0] = 128'h2222222222222222_0000000000000000; b2b_ready[0] = 1'b0;
        b2b_beats[1] = 128'h1111111111111111_0000000000000000; b2b_ready[1] = 1'b1;
        b2b_beats[2] = 128'h3333333333333333_4444444444444444; b2b_ready[2] = 1'b1;
        b2b_beats[3] = 128'h6666666666666666_0000000000000000; b2b_ready[3] = 1'b0;
        b2b_beats[4] = 128'h5555555555555555_0000000000000000; b2b_ready[4] = 1'b1;
        b2b_beats[5] = 128'h7777777777777777_8888888888888888; b2b_ready[5] = 1'b1;
        begin
            int widx;
            logic acc;
            widx = 0;
            @(negedge clk);
            i_word = b2b_words[0]; i_push_flag = b2b_flags[0]; i_valid = 1'b1; i_ready = 1'b1;
            @(posedge clk); #1;
            widx = 1; i_word = b2b_words[1]; i_push_flag = b2b_flags[1];
            for (int k = 0; k < 6; k++) begin
                @(negedge clk);
                chk("b2b_valid", o_valid, 1);
                chk("b2b_word",  o_word, b2b_beats[k]);
                chk("b2b_ready", o_ready, b2b_ready[k]);
                acc = o_ready && i_valid;
                @(posedge clk); #1;
                if (acc) begin
                    widx++;
                    if (widx < 4) begin
                        i_word = b2b_words[widx]; i_push_flag = b2b_flags[widx];
                    end else begin
                        i_valid = 1'b0;
                    end
                end
            end
        end
        exp_cnt += 4;
        @(negedge clk);
        check_idle();

        // Reset while in HIGH
        @(negedge clk);
        i_word = vecs[0].word; i_push_flag = 1'b0; i_valid = 1'b1; i_ready = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        @(posedge clk); #1;
        i_ready = 1'b0;
        @(negedge clk);
        chk("rh_half_pre", o_half, 1);
        #2 i_reset = 1'b0;
        #1;
        chk("rh_valid", o_valid, 0);
        chk("rh_word",  o_word, 0);
        chk("rh_half",  o_half, 0);
        chk("rh_ready", o_ready, 0);
        chk("rh_cnt",   o_word_cnt, 0);
        exp_cnt = 0;
        @(negedge clk);
        i_reset = 1'b1; i_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rh_after_valid", o_valid, 0);
        end

        // Counter wrap: 65536 whole words back to back
        @(negedge clk);
        i_word = 128'hC0FFEE; i_push_flag = 1'b1; i_valid = 1'b1; i_ready = 1'b1;
        for (int i = 0; i < 65536; i++) begin
            @(posedge clk); #1;
        end
        i_valid = 1'b0;
        @(negedge clk);
        chk("wrap_pre_cnt",   o_word_cnt, 16'hFFFF);
        chk("wrap_pre_valid", o_valid, 1);
        @(negedge clk);
        chk("wrap_cnt",   o_word_cnt, 16'h0000);
        chk("wrap_valid", o_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
